// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared state encoding and timer width for the SR latch pulse driver
package sr_drv_pkg;

  localparam int TIMER_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // A phase of N cycles is timed by loading N-1 and leaving when the count reads zero.
  function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// rtl/sr_drv_timer.sv - loadable 4-bit down-counter that holds at zero, with zero flag
module sr_drv_timer
  import sr_drv_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - SR latch set/clear pulse driver; SR_DRV_READBACK_EN enables q_fb check
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic Sbar,
  output logic Rbar,
  output logic busy,
  output logic done,
  output logic err
);

  state_t             state;
  logic               dir_set;
  logic               armed;
  logic               q_meta;
  logic               q_sync;
  logic               accept;
  logic               req_both;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_en;
  logic               tmr_zero;

  // armed stays low for the first edge after reset so a request held through reset is dropped.
  assign accept   = (state == IDLE) && armed && (set_req ^ clr_req);
  assign req_both = (state == IDLE) && armed && set_req && clr_req;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = phase_load(PULSE_CYCLES);
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        tmr_load = accept;
      end
      PULSE: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = phase_load(SETTLE_CYCLES);
        end else begin
          tmr_en = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        tmr_load  = 1'b1;
        tmr_value = '0;
      end
    endcase
  end

  sr_drv_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dir_set <= 1'b0;
      armed   <= 1'b0;
      q_meta  <= 1'b0;
      q_sync  <= 1'b0;
      Sbar    <= 1'b1;
      Rbar    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      armed  <= 1'b1;
      q_meta <= q_fb;
      q_sync <= q_meta;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          Sbar <= 1'b1;
          Rbar <= 1'b1;
          if (req_both) begin
            err <= 1'b1;
          end else if (accept) begin
            dir_set <= set_req;
            busy    <= 1'b1;
            Sbar    <= ~set_req;
            Rbar    <= set_req;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_zero) begin
            Sbar  <= 1'b1;
            Rbar  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef SR_DRV_READBACK_EN
          if (q_sync != dir_set) begin
            err <= 1'b1;
          end
`endif
        end
        default: begin
          Sbar  <= 1'b1;
          Rbar  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SR_DRV_READBACK_EN
  // Readback is compiled out; the synchronizer still runs but its output has no consumer.
  logic unused_q_sync;
  assign unused_q_sync = q_sync;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - scoreboard bench for sr_pulse_driver (default and 1/1 timing instances)
module tb_sr_pulse_driver;

  logic clock = 1'b0;
  logic reset_n;
  logic set1, clr1, qfb1, sbar1, rbar1, busy1, done1, err1;
  logic set2, clr2, qfb2, sbar2, rbar2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q1[$];
  int q2[$];
  bit exp_err;

  always #5 clock = ~clock;

  sr_pulse_driver dut1 (
    .clock(clock), .reset_n(reset_n), .set_req(set1), .clr_req(clr1), .q_fb(qfb1),
    .Sbar(sbar1), .Rbar(rbar1), .busy(busy1), .done(done1), .err(err1)
  );

  sr_pulse_driver #(.PULSE_CYCLES(1), .SETTLE_CYCLES(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .set_req(set2), .clr_req(clr2), .q_fb(qfb2),
    .Sbar(sbar2), .Rbar(rbar2), .busy(busy2), .done(done2), .err(err2)
  );

  // Advance to the next falling edge and run the per-cycle scoreboard checks.
  task automatic tick();
    int e;
    @(negedge clock);
    cyc++;
    checks++;
    if (!sbar1 && !rbar1) begin
      errors++;
      $display("FAIL both_low_dut1 cycle %0d got Sbar=0 Rbar=0 required not both 0", cyc);
    end
    checks++;
    if (!sbar2 && !rbar2) begin
      errors++;
      $display("FAIL both_low_dut2 cycle %0d got Sbar=0 Rbar=0 required not both 0", cyc);
    end
    if (done1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL done_dut1 got done at cycle %0d required none", cyc);
      end else begin
        e = q1.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL done_dut1 got done at cycle %0d required cycle %0d", cyc, e);
        end
      end
    end
    if (done2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL done_dut2 got done at cycle %0d required none", cyc);
      end else begin
        e = q2.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL done_dut2 got done at cycle %0d required cycle %0d", cyc, e);
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending dones required 0/0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set1 = 0; clr1 = 0; qfb1 = 1; set2 = 0; clr2 = 0; qfb2 = 0;
    tick(); tick();
    checks++;
    if ({sbar1, rbar1, busy1, done1, err1} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs got %b required 11000", {sbar1, rbar1, busy1, done1, err1});
    end
    reset_n = 1'b1;
    set1 = 1'b1;
    tick();
    set1 = 1'b0;
    tick(); tick();
    checks++;
    if (busy1 !== 1'b0 || sbar1 !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_ignored got busy=%b Sbar=%b required busy=0 Sbar=1", busy1, sbar1);
    end
    exp_err = 1'b0;
  endtask

  task automatic test_set();
    int slow = 0, rlow = 0;
    qfb1 = 1'b1;
    set1 = 1'b1;
    q1.push_back(cyc + 8);
    tick();
    set1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL set_busy got %b required 1", busy1);
    end
    for (int i = 0; i < 10; i++) begin
      if (!sbar1) slow++;
      if (!rbar1) rlow++;
      tick();
    end
    drain();
    checks++;
    if (slow !== 4 || rlow !== 0) begin
      errors++;
      $display("FAIL set_pulse got Sbar low %0d Rbar low %0d required 4 and 0", slow, rlow);
    end
    checks++;
    if (err1 !== exp_err || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL set_end got err=%b busy=%b required err=%b busy=0", err1, busy1, exp_err);
    end
  endtask

  task automatic test_clr_readback();
    int slow = 0, rlow = 0;
    qfb1 = 1'b1;
    clr1 = 1'b1;
    q1.push_back(cyc + 8);
    tick();
    clr1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!sbar1) slow++;
      if (!rbar1) rlow++;
      tick();
    end
    drain();
`ifdef SR_DRV_READBACK_EN
    exp_err = 1'b1;
`endif
    checks++;
    if (rlow !== 4 || slow !== 0) begin
      errors++;
      $display("FAIL clr_pulse got Rbar low %0d Sbar low %0d required 4 and 0", rlow, slow);
    end
    repeat (5) tick();
    checks++;
    if (err1 !== exp_err) begin
      errors++;
      $display("FAIL clr_readback_err got %b required %b", err1, exp_err);
    end
  endtask

  task automatic test_both();
    int low = 0, bsy = 0;
    set1 = 1'b1;
    clr1 = 1'b1;
    tick();
    set1 = 1'b0;
    clr1 = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!sbar1 || !rbar1) low++;
      if (busy1) bsy++;
      tick();
    end
    checks++;
    if (low !== 0 || bsy !== 0) begin
      errors++;
      $display("FAIL both_req got low cycles %0d busy cycles %0d required 0 and 0", low, bsy);
    end
    checks++;
    if (err1 !== 1'b1) begin
      errors++;
      $display("FAIL both_req_err got %b required 1", err1);
    end
  endtask

  task automatic test_ignore();
    int rlow = 0, slow = 0;
    set1 = 1'b1;
    q1.push_back(cyc + 8);
    tick();
    set1 = 1'b0;
    if (!sbar1) slow++;
    tick();
    clr1 = 1'b1;
    if (!sbar1) slow++;
    tick();
    clr1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!sbar1) slow++;
      if (!rbar1) rlow++;
      tick();
    end
    drain();
    checks++;
    if (rlow !== 0 || slow !== 4) begin
      errors++;
      $display("FAIL ignore_clr got Rbar low %0d Sbar low %0d required 0 and 4", rlow, slow);
    end
    checks++;
    if (err1 !== exp_err) begin
      errors++;
      $display("FAIL err_sticky got %b required %b", err1, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    set1 = 1'b1;
    q1.push_back(cyc + 8);
    tick();
    set1 = 1'b0;
    tick(); tick();
    checks++;
    if (sbar1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse_sbar got %b required 0", sbar1);
    end
    #2;
    reset_n = 1'b0;
    q1.delete();
    exp_err = 1'b0;
    #1;
    checks++;
    if ({sbar1, rbar1, busy1, done1, err1} !== 5'b11000) begin
      errors++;
      $display("FAIL async_reset got %b required 11000", {sbar1, rbar1, busy1, done1, err1});
    end
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if ({sbar1, rbar1, busy1, err1} !== 4'b1100) begin
      errors++;
      $display("FAIL after_reset got %b required 1100", {sbar1, rbar1, busy1, err1});
    end
  endtask

  task automatic test_back_to_back();
    int slow = 0, rlow = 0;
    set2 = 1'b1;
    q2.push_back(cyc + 4);
    tick();
    set2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!sbar2) slow++;
      if (!rbar2) rlow++;
      tick();
    end
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done got done=%b busy=%b required done=1 busy=0", done2, busy2);
    end
    clr2 = 1'b1;
    q2.push_back(cyc + 4);
    tick();
    clr2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!sbar2) slow++;
      if (!rbar2) rlow++;
      tick();
    end
    drain();
    checks++;
    if (slow !== 1 || rlow !== 1) begin
      errors++;
      $display("FAIL b2b_pulses got Sbar low %0d Rbar low %0d required 1 and 1", slow, rlow);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_clr_readback();
    test_both();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
